slave_regfile: RTL and testbench

Bus slave that terminates the two-phase `bus_if` transfers issued by the bus master, directly downstream of it on `busa`. It holds a bank of `NUM_REGS` 32-bit registers and acknowledges each address phase and data phase with a one-cycle `ready` pulse after a programmable number of wait states. Read data is returned in the data-phase acknowledge cycle. Writes commit at that edge.

---
 rtl/bus_pkg.sv | 23 ++
 rtl/bus_if.sv | 23 ++
 rtl/slave_regfile_reg_bank.sv | 49 ++++
 rtl/slave_regfile.sv | 154 +++++++++++++++
 tb/tb_slave_regfile.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// Shared widths, slave FSM state encoding and helpers for the bus_if slave side.
package bus_pkg;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 32;

   localparam logic [DATA_W-1:0] ERR_READ_DATA = 32'h0;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ADDR_WAIT = 3'd1,
      ADDR_ACK  = 3'd2,
      DATA_WAIT = 3'd3,
      DATA_ACK  = 3'd4
   } slv_state_t;

   // One extra bit so an address below the base shows up as a borrow, never a wrap.
   function automatic logic [ADDR_W:0] addr_offset(input logic [ADDR_W-1:0] addr,
                                                   input logic [ADDR_W-1:0] base);
      return {1'b0, addr} - {1'b0, base};
   endfunction

endpackage

// File: rtl/bus_if.sv
// Two-phase master/slave transfer bundle shared by the bus master and its slaves.
interface bus_if;
   import bus_pkg::*;

   logic              valid;
   logic              read;
   logic              write;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] write_data;
   logic              ready;
   logic [DATA_W-1:0] read_data;

   modport master (
      output valid, read, write, addr, write_data,
      input  ready, read_data
   );

   modport slave (
      input  valid, read, write, addr, write_data,
      output ready, read_data
   );

endinterface

// File: rtl/slave_regfile_reg_bank.sv
// Register storage for slave_regfile: one write port gated by RO_MASK, one combinational read port.
module reg_bank
   import bus_pkg::*;
#(
   parameter int                  NUM_REGS = 8,
   parameter int                  IDX_W    = 3,
   parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ro,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] regs_reg [NUM_REGS];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         always_ff @(posedge clk) begin
            if (reset) begin
               regs_reg[gi] <= '0;
            end else if (wr_en && !RO_MASK[gi] && (wr_idx == IDX_W'(gi))) begin
               regs_reg[gi] <= wr_data;
            end
         end
      end
   endgenerate

   // Indices beyond NUM_REGS never match, so they read as zero and look writable;
   // the caller's range check rejects them before they get here.
   always_comb begin
      rd_data = '0;
      wr_ro   = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rd_idx == IDX_W'(i)) begin
            rd_data = regs_reg[i];
         end
         if (wr_idx == IDX_W'(i)) begin
            wr_ro = RO_MASK[i];
         end
      end
   end

endmodule

// File: rtl/slave_regfile.sv
// bus_if slave terminating two-phase transfers into a bank of 32-bit registers,
// with a fixed number of wait states ahead of each ready pulse.
module slave_regfile
   import bus_pkg::*;
#(
   parameter int                  NUM_REGS    = 8,
   parameter logic [ADDR_W-1:0]   BASE_ADDR   = 16'h0000,
   parameter int                  WAIT_CYCLES = 0,
   parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
   input  logic clk,
   input  logic reset,
   bus_if.slave busa,
   output logic err,
   output logic busy
);

   localparam int                IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [ADDR_W:0]   REG_COUNT = (ADDR_W + 1)'(NUM_REGS);
   localparam logic [3:0]        WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   slv_state_t        state_reg, state_next;
   logic [3:0]        cnt_reg, cnt_next;
   logic [ADDR_W-1:0] cap_addr_reg;
   logic              cap_read_reg;
   logic              cap_write_reg;
   logic [DATA_W-1:0] read_data_reg;

   logic [ADDR_W:0]   live_off, cap_off;
   logic              live_hit, cap_hit;
   logic [IDX_W-1:0]  live_idx, cap_idx, rd_idx;
   logic              live_rd_ok, cap_rd_ok, cap_wr_ok, cap_ok;
   logic              wr_ro;
   logic              rd_ok_sel;
   logic              load_rd;
   logic              commit;
   logic [DATA_W-1:0] bank_rd_data;

   assign live_off = addr_offset(busa.addr, BASE_ADDR);
   assign cap_off  = addr_offset(cap_addr_reg, BASE_ADDR);
   assign live_hit = !live_off[ADDR_W] && (live_off < REG_COUNT);
   assign cap_hit  = !cap_off[ADDR_W] && (cap_off < REG_COUNT);
   assign live_idx = live_off[IDX_W-1:0];
   assign cap_idx  = cap_off[IDX_W-1:0];

   assign live_rd_ok = busa.read && !busa.write && live_hit;
   assign cap_rd_ok  = cap_read_reg && !cap_write_reg && cap_hit;
   assign cap_wr_ok  = cap_write_reg && !cap_read_reg && cap_hit && !wr_ro;
   assign cap_ok     = cap_rd_ok || cap_wr_ok;

   // With no wait states DATA_ACK follows ADDR_ACK directly, before the capture
   // registers have loaded, so the read port must look at the live bus instead.
   assign rd_idx    = (state_reg == ADDR_ACK) ? live_idx : cap_idx;
   assign rd_ok_sel = (state_reg == ADDR_ACK) ? live_rd_ok : cap_rd_ok;

   assign commit = (state_reg == DATA_ACK) && busa.valid && cap_wr_ok && !reset;

   assign busa.ready     = (state_reg == ADDR_ACK) || (state_reg == DATA_ACK);
   assign busa.read_data = read_data_reg;
   assign busy           = (state_reg != IDLE);
   assign err            = (state_reg == DATA_ACK) && busa.valid && !cap_ok;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      load_rd    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (busa.valid) begin
               if (WAIT_CYCLES == 0) begin
                  state_next = ADDR_ACK;
               end else begin
                  state_next = ADDR_WAIT;
                  cnt_next   = WAIT_LOAD;
               end
            end
         end
         ADDR_WAIT: begin
            if (!busa.valid) begin
               state_next = IDLE;
            end else if (cnt_reg == 4'd0) begin
               state_next = ADDR_ACK;
            end else begin
               cnt_next = cnt_reg - 4'd1;
            end
         end
         ADDR_ACK: begin
            if (!busa.valid) begin
               state_next = IDLE;
            end else if (WAIT_CYCLES == 0) begin
               state_next = DATA_ACK;
               load_rd    = 1'b1;
            end else begin
               state_next = DATA_WAIT;
               cnt_next   = WAIT_LOAD;
            end
         end
         DATA_WAIT: begin
            if (!busa.valid) begin
               state_next = IDLE;
            end else if (cnt_reg == 4'd0) begin
               state_next = DATA_ACK;
               load_rd    = 1'b1;
            end else begin
               cnt_next = cnt_reg - 4'd1;
            end
         end
         DATA_ACK: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         cap_addr_reg  <= '0;
         cap_read_reg  <= 1'b0;
         cap_write_reg <= 1'b0;
         read_data_reg <= ERR_READ_DATA;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if ((state_reg == ADDR_ACK) && busa.valid) begin
            cap_addr_reg  <= busa.addr;
            cap_read_reg  <= busa.read;
            cap_write_reg <= busa.write;
         end
         if (load_rd) begin
            read_data_reg <= rd_ok_sel ? bank_rd_data : ERR_READ_DATA;
         end
      end
   end

   reg_bank #(
      .NUM_REGS (NUM_REGS),
      .IDX_W    (IDX_W),
      .RO_MASK  (RO_MASK)
   ) u_reg_bank (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (commit),
      .wr_idx  (cap_idx),
      .wr_data (busa.write_data),
      .wr_ro   (wr_ro),
      .rd_idx  (rd_idx),
      .rd_data (bank_rd_data)
   );

endmodule

// File: tb/tb_slave_regfile.sv
// Bench for slave_regfile: two configurations driven with directed and random transfers,
// checked every cycle against a transfer-level schedule and register-array model.
module tb_slave_regfile;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]  v, rd, wr, rst;
   logic [15:0] ad [2];
   logic [31:0] wd [2];
   logic        err0, err1, busy0, busy1;

   bus_if bus0 ();
   bus_if bus1 ();

   assign bus0.valid      = v[0];
   assign bus0.read       = rd[0];
   assign bus0.write      = wr[0];
   assign bus0.addr       = ad[0];
   assign bus0.write_data = wd[0];
   assign bus1.valid      = v[1];
   assign bus1.read       = rd[1];
   assign bus1.write      = wr[1];
   assign bus1.addr       = ad[1];
   assign bus1.write_data = wd[1];

   slave_regfile #(
      .NUM_REGS(8), .BASE_ADDR(16'h0000), .WAIT_CYCLES(0), .RO_MASK(8'h00)
   ) dut0 (
      .clk(clk), .reset(rst[0]), .busa(bus0), .err(err0), .busy(busy0)
   );

   slave_regfile #(
      .NUM_REGS(8), .BASE_ADDR(16'h0010), .WAIT_CYCLES(3), .RO_MASK(8'h01)
   ) dut1 (
      .clk(clk), .reset(rst[1]), .busa(bus1), .err(err1), .busy(busy1)
   );

   // Model configuration, mirrors the parameters above.
   int          wc     [2] = '{0, 3};
   logic [15:0] base_m [2] = '{16'h0000, 16'h0010};
   logic [7:0]  ro_m   [2] = '{8'h00, 8'h01};

   // Scoreboard / schedule state per DUT.
   int          t0 [2], mode [2], cut [2];
   int          rdy_n [2], rk0 [2], rk1 [2], bcnt [2], errn [2];
   logic        act_m [2], mon_en [2], efail [2];
   logic [31:0] new_rd [2], cur_rd [2];
   logic [31:0] mregs [2][8];
   int          cyc, tests, fails;

   function automatic logic o_rdy(int d);
      return (d == 0) ? bus0.ready : bus1.ready;
   endfunction
   function automatic logic [31:0] o_rdata(int d);
      return (d == 0) ? bus0.read_data : bus1.read_data;
   endfunction
   function automatic logic o_err(int d);
      return (d == 0) ? err0 : err1;
   endfunction
   function automatic logic o_busy(int d);
      return (d == 0) ? busy0 : busy1;
   endfunction

   function automatic int model_off(int d, logic [15:0] a);
      return int'(a) - int'(base_m[d]);
   endfunction

   function automatic logic model_fail(int d, logic r, logic w, logic [15:0] a);
      int off;
      off = model_off(d, a);
      if (r == w) return 1'b1;
      if (off < 0 || off >= 8) return 1'b1;
      if (w && ro_m[d][off]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic check(string name, logic [31:0] got, logic [31:0] req);
      tests++;
      if (got !== req) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, got, req);
      end
   endtask

   // Expected outputs follow from the transfer schedule: ready at offsets W+1 and
   // 2W+2 after the accepting IDLE cycle, busy in between, abort ends it early.
   task automatic compare_all();
      for (int d = 0; d < 2; d++) begin
         int          k, w, last;
         logic        e_busy, e_rdy, e_err;
         logic [31:0] e_rd;
         if (!mon_en[d]) continue;
         w      = wc[d];
         k      = cyc - t0[d];
         e_busy = 1'b0;
         e_rdy  = 1'b0;
         e_err  = 1'b0;
         e_rd   = cur_rd[d];
         if (act_m[d]) begin
            last   = (mode[d] == 1) ? cut[d] : 2 * w + 2;
            e_busy = (k >= 1) && (k <= last);
            e_rdy  = ((k == w + 1) && (k <= last)) || ((k == 2 * w + 2) && (mode[d] != 1));
            if ((k == 2 * w + 2) && (mode[d] != 1)) begin
               e_err     = efail[d];
               e_rd      = new_rd[d];
               cur_rd[d] = new_rd[d];
            end
         end
         if (o_rdy(d)) begin
            if (rdy_n[d] == 0) rk0[d] = k;
            else rk1[d] = k;
            rdy_n[d]++;
         end
         if (o_busy(d)) bcnt[d]++;
         if (o_err(d)) errn[d]++;
         check($sformatf("dut%0d_ready k=%0d", d, k), 32'(o_rdy(d)), 32'(e_rdy));
         check($sformatf("dut%0d_busy k=%0d", d, k), 32'(o_busy(d)), 32'(e_busy));
         check($sformatf("dut%0d_err k=%0d", d, k), 32'(o_err(d)), 32'(e_err));
         check($sformatf("dut%0d_rdata k=%0d", d, k), o_rdata(d), e_rd);
      end
   endtask

   task automatic step();
      @(negedge clk);
      compare_all();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic clear_model(int d);
      for (int i = 0; i < 8; i++) mregs[d][i] = 32'h0;
   endtask

   task automatic reset_dut(int d);
      rst[d]    = 1'b1;
      v[d]      = 1'b0;
      mon_en[d] = 1'b0;
      act_m[d]  = 1'b0;
      step();
      step();
      rst[d]    = 1'b0;
      cur_rd[d] = 32'h0;
      clear_model(d);
      mon_en[d] = 1'b1;
      check($sformatf("dut%0d_reset_ready", d), 32'(o_rdy(d)), 0);
      check($sformatf("dut%0d_reset_busy", d), 32'(o_busy(d)), 0);
      check($sformatf("dut%0d_reset_err", d), 32'(o_err(d)), 0);
      check($sformatf("dut%0d_reset_rdata", d), o_rdata(d), 32'h0);
   endtask

   task automatic idle(int d, int n);
      v[d] = 1'b0;
      repeat (n) step();
   endtask

   // md: 0 normal, 1 drop valid at offset ct, 2 assert reset at offset ct.
   task automatic xfer(int d, logic r, logic w, logic [15:0] a, logic [31:0] dat, int md, int ct);
      int off;
      t0[d]    = cyc;
      act_m[d] = 1'b1;
      mode[d]  = md;
      cut[d]   = ct;
      off      = model_off(d, a);
      efail[d] = model_fail(d, r, w, a);
      new_rd[d] = (!efail[d] && r) ? mregs[d][off] : 32'h0;
      if (!efail[d] && w && md == 0) mregs[d][off] = dat;
      rdy_n[d] = 0; bcnt[d] = 0; errn[d] = 0; rk0[d] = -1; rk1[d] = -1;
      v[d] = 1'b1; rd[d] = r; wr[d] = w; ad[d] = a; wd[d] = dat;
      $display("[TB] dut%0d cyc=%0d rd=%b wr=%b addr=%h wdata=%h mode=%0d cut=%0d exp_err=%b exp_rdata=%h",
               d, cyc, r, w, a, dat, md, ct, efail[d], new_rd[d]);
      if (md == 1) begin
         repeat (ct) step();
         v[d] = 1'b0;
         step();
      end else if (md == 2) begin
         repeat (ct) step();
         rst[d] = 1'b1;
         step();
         rst[d]    = 1'b0;
         v[d]      = 1'b0;
         act_m[d]  = 1'b0;
         cur_rd[d] = 32'h0;
         clear_model(d);
      end else begin
         repeat (2 * wc[d] + 3) step();
      end
   endtask

   task automatic random_run(int d, int n);
      for (int i = 0; i < n; i++) begin
         int          sel, md, ct;
         logic        r, w;
         logic [15:0] a;
         logic [31:0] dat;
         sel = int'($urandom_range(0, 9));
         r   = (sel < 4) || (sel == 8);
         w   = (sel >= 4 && sel < 8) || (sel == 8);
         a   = 16'(32'(base_m[d]) + $urandom_range(0, 11) - 32'd2);
         dat = $urandom;
         md  = 0;
         ct  = 0;
         if ($urandom_range(0, 7) == 0) begin
            md = 1;
            ct = int'($urandom_range(1, 32'(2 * wc[d] + 1)));
         end
         xfer(d, r, w, a, dat, md, ct);
         if ($urandom_range(0, 2) == 0) idle(d, int'($urandom_range(1, 3)));
      end
      idle(d, 2);
   endtask

   initial begin
      v = '0; rd = '0; wr = '0; rst = 2'b11;
      for (int d = 0; d < 2; d++) begin
         ad[d] = 16'h0; wd[d] = 32'h0;
         t0[d] = 0; mode[d] = 0; cut[d] = 0;
         rdy_n[d] = 0; rk0[d] = -1; rk1[d] = -1; bcnt[d] = 0; errn[d] = 0;
         act_m[d] = 1'b0; mon_en[d] = 1'b0; efail[d] = 1'b0;
         new_rd[d] = 32'h0; cur_rd[d] = 32'h0;
      end
      cyc = 0; tests = 0; fails = 0;
      @(posedge clk);
      #1;
      reset_dut(0);
      reset_dut(1);

      // Zero wait states: ready in cycles 1 and 2, fresh register reads zero.
      xfer(0, 1'b1, 1'b0, 16'h0001, 32'h0, 0, 0);
      check("d0_first_ready_cycle", rk0[0], 1);
      check("d0_second_ready_cycle", rk1[0], 2);
      check("d0_first_rdata", o_rdata(0), 32'h0);
      check("d0_first_errs", errn[0], 0);
      idle(0, 1);
      xfer(0, 1'b0, 1'b1, 16'h0001, 32'hDEACBEFF, 0, 0);
      xfer(0, 1'b1, 1'b0, 16'h0001, 32'h0, 0, 0);
      check("d0_write_visible", o_rdata(0), 32'hDEACBEFF);
      xfer(0, 1'b1, 1'b0, 16'h0008, 32'h0, 0, 0);
      check("d0_oob_err", errn[0], 1);
      check("d0_oob_rdata", o_rdata(0), 32'h0);
      xfer(0, 1'b1, 1'b1, 16'h0002, 32'h1, 0, 0);
      check("d0_rdwr_err", errn[0], 1);
      idle(0, 2);

      // Three wait states: ready only in cycles 4 and 8, busy in 1..8.
      xfer(1, 1'b1, 1'b0, 16'h0010, 32'h0, 0, 0);
      check("d1_ready_count", rdy_n[1], 2);
      check("d1_addr_ready_cycle", rk0[1], 4);
      check("d1_data_ready_cycle", rk1[1], 8);
      check("d1_busy_cycles", bcnt[1], 8);
      xfer(1, 1'b0, 1'b1, 16'h000F, 32'hCAFE0001, 0, 0);
      check("d1_below_base_err", errn[1], 1);
      check("d1_below_base_rdata", o_rdata(1), 32'h0);
      xfer(1, 1'b0, 1'b1, 16'h0010, 32'h00001234, 0, 0);
      check("d1_ro_err", errn[1], 1);
      xfer(1, 1'b1, 1'b0, 16'h0010, 32'h0, 0, 0);
      check("d1_ro_readback", o_rdata(1), 32'h0);
      xfer(1, 1'b0, 1'b1, 16'h0011, 32'h00000055, 0, 0);
      xfer(1, 1'b1, 1'b0, 16'h0011, 32'h0, 0, 0);
      check("d1_write_visible", o_rdata(1), 32'h00000055);

      // Abort in DATA_WAIT of a write.
      xfer(1, 1'b0, 1'b1, 16'h0012, 32'h0000AAAA, 1, 6);
      check("d1_abort_ready_count", rdy_n[1], 1);
      check("d1_abort_errs", errn[1], 0);
      check("d1_abort_idle", 32'(o_busy(1)), 0);
      idle(1, 2);
      xfer(1, 1'b1, 1'b0, 16'h0012, 32'h0, 0, 0);
      check("d1_abort_no_write", o_rdata(1), 32'h0);

      // Reset landing on DATA_ACK of a write.
      xfer(1, 1'b0, 1'b1, 16'h0013, 32'h00000077, 0, 0);
      xfer(1, 1'b1, 1'b0, 16'h0013, 32'h0, 0, 0);
      check("d1_pre_reset_value", o_rdata(1), 32'h00000077);
      xfer(1, 1'b0, 1'b1, 16'h0013, 32'h00000099, 2, 8);
      check("d1_midreset_ready", 32'(o_rdy(1)), 0);
      check("d1_midreset_busy", 32'(o_busy(1)), 0);
      check("d1_midreset_err", 32'(o_err(1)), 0);
      check("d1_midreset_rdata", o_rdata(1), 32'h0);
      idle(1, 1);
      xfer(1, 1'b1, 1'b0, 16'h0013, 32'h0, 0, 0);
      check("d1_midreset_no_write", o_rdata(1), 32'h0);
      idle(1, 1);

      random_run(0, 200);
      random_run(1, 80);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
